stream_mux_rr: RTL

//   Parametrised N-channel, WIDTH-bit registered multiplexer: the clocked successor to the 3-input

---
 rtl/stream_mux_rr.sv | 117 +++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// ----------------------------------------------------------------------------
// stream_mux_rr: N-channel valid/ready stream mux with fixed or round-robin
// selection and a single registered output stage.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int CH    = 3,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   in_data_i,
  input  logic [CH-1:0]         in_valid_i,
  output logic [CH-1:0]         in_ready_o,
  input  logic                  mode_i,
  input  logic [SELW-1:0]       sel_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [SELW-1:0]       grant_o
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  grant_q;
  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  ptr_d;

  logic             w_load;
  logic             w_chosen;
  logic [SELW-1:0]  w_chan;
  logic [WIDTH-1:0] w_chan_data;

  assign w_load = !out_valid_q || out_ready_i;

  // Fixed mode only honours sel when it names an existing, valid channel;
  // round-robin scans from ptr upward and wraps, first valid channel wins.
  always_comb begin : p_choose
    int idx;
    idx      = 0;
    w_chosen = 1'b0;
    w_chan   = '0;
    if (!mode_i) begin
      for (int k = 0; k < CH; k++) begin
        if (!w_chosen && sel_i == SELW'(k) && in_valid_i[k]) begin
          w_chosen = 1'b1;
          w_chan   = SELW'(k);
        end
      end
    end else begin
      for (int off = 0; off < CH; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= CH) begin
          idx = idx - CH;
        end
        for (int k = 0; k < CH; k++) begin
          if (!w_chosen && k == idx && in_valid_i[k]) begin
            w_chosen = 1'b1;
            w_chan   = SELW'(k);
          end
        end
      end
    end
  end

  always_comb begin : p_data
    w_chan_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (w_chan == SELW'(k)) begin
        w_chan_data = in_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : p_ready
    in_ready_o = '0;
    for (int k = 0; k < CH; k++) begin
      in_ready_o[k] = !rst && w_load && w_chosen && (w_chan == SELW'(k));
    end
  end

  always_comb begin : p_ptr
    ptr_d = ptr_q;
    if (mode_i && w_load && w_chosen) begin
      ptr_d = (w_chan == SELW'(CH - 1)) ? '0 : w_chan + SELW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (w_load) begin
        if (w_chosen) begin
          out_data_q  <= w_chan_data;
          out_valid_q <= 1'b1;
          grant_q     <= w_chan;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign grant_o     = grant_q;

endmodule

`default_nettype wire
